decode_queue: RTL and testbench

//  Buffered, registered successor of the single-cycle decoder. Sits between ifetch and dispatch (ROB/RS/LSB).

---
 rtl/decode_queue.sv | 258 +++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - instruction queue feeding a registered decode stage
// Head of a DEPTH-entry queue is decoded, resolved against regfile/ROB/CDB and held for dispatch.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int ROB_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [31:0]            if_inst,
  input  logic [31:0]            if_pc,
  input  logic                   if_is_jump,
  output logic [4:0]             rs1_index,
  output logic [4:0]             rs2_index,
  input  logic                   rs1_dirty,
  input  logic [ROB_W-1:0]       rs1_rob_entry,
  input  logic [31:0]            rs1_value,
  input  logic                   rs2_dirty,
  input  logic [ROB_W-1:0]       rs2_rob_entry,
  input  logic [31:0]            rs2_value,
  output logic [ROB_W-1:0]       rs1_rob_q_entry,
  output logic [ROB_W-1:0]       rs2_rob_q_entry,
  input  logic [31:0]            rs1_rob_value,
  input  logic                   rs1_rob_rdy,
  input  logic [31:0]            rs2_rob_value,
  input  logic                   rs2_rob_rdy,
  input  logic [ROB_W-1:0]       next_empty_rob_entry,
  input  logic                   cdb_valid,
  input  logic [ROB_W-1:0]       cdb_rob_id,
  input  logic [31:0]            cdb_value,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [6:0]             out_opcode,
  output logic [2:0]             out_funct3,
  output logic                   out_funct7b5,
  output logic [4:0]             out_rd,
  output logic [31:0]            out_rs1_val,
  output logic                   out_rs1_need_rob,
  output logic [ROB_W-1:0]       out_rs1_rob_id,
  output logic [31:0]            out_rs2_val,
  output logic                   out_rs2_need_rob,
  output logic [ROB_W-1:0]       out_rs2_rob_id,
  output logic [31:0]            out_imm,
  output logic                   out_lsb,
  output logic                   out_store,
  output logic                   out_rs,
  output logic [ROB_W-1:0]       out_rob_id,
  output logic [31:0]            out_pc,
  output logic                   out_is_jump,
  output logic [$clog2(DEPTH):0] iq_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BR = 7'b1100011, OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011, OPC_OPI = 7'b0010011, OPC_OP = 7'b0110011;

  typedef struct packed {
    logic [31:0]      val;
    logic             need;
    logic [ROB_W-1:0] id;
  } opnd_t;

  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic          jump_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          push, fire, load;
  logic [31:0]   hd;
  logic [31:0]   d_imm;
  logic [4:0]    d_rd;
  logic          d_rs, d_lsb, d_store, use1, use2;
  logic          fwd1, fwd2, snp1, snp2;
  opnd_t         op1, op2;

  // Priority: in-flight dispatch forward, regfile, ROB, same-cycle CDB, else wait on tag.
  function automatic opnd_t resolve(input logic used, input logic fwd, input logic [ROB_W-1:0] fwd_id,
                                    input logic dirty, input logic [31:0] rf_val,
                                    input logic [ROB_W-1:0] ent, input logic rob_rdy,
                                    input logic [31:0] rob_val, input logic cdb_hit,
                                    input logic [31:0] cdb_val);
    opnd_t r;
    r = '0;
    if (used) begin
      if (fwd) begin
        r.need = 1'b1;
        r.id   = fwd_id;
      end else if (!dirty) r.val = rf_val;
      else if (rob_rdy) r.val = rob_val;
      else if (cdb_hit) r.val = cdb_val;
      else begin
        r.need = 1'b1;
        r.id   = ent;
      end
    end
    return r;
  endfunction

  assign hd              = inst_q[head];
  assign rs1_index       = hd[19:15];
  assign rs2_index       = hd[24:20];
  assign rs1_rob_q_entry = rs1_rob_entry;
  assign rs2_rob_q_entry = rs2_rob_entry;
  assign if_ready        = count < CW'(DEPTH);
  assign iq_count        = count;
  assign fire            = out_valid & out_ready;
  assign push            = rdy & ~rollback & if_valid & if_ready;
  assign load            = rdy & ~rollback & (count != '0) & (~out_valid | fire);

  always_comb begin
    d_imm   = '0;
    d_rd    = hd[11:7];
    d_rs    = 1'b0;
    d_lsb   = 1'b0;
    d_store = 1'b0;
    use1    = 1'b1;
    use2    = 1'b0;
    case (hd[6:0])
      OPC_LUI: begin
        d_imm = {hd[31:12], 12'b0};
        use1  = 1'b0;
      end
      OPC_AUIPC: begin
        d_imm = {hd[31:12], 12'b0};
        use1  = 1'b0;
        d_rs  = 1'b1;
      end
      OPC_JAL: begin
        d_imm = {{11{hd[31]}}, hd[31], hd[19:12], hd[20], hd[30:21], 1'b0};
        use1  = 1'b0;
        d_rs  = 1'b1;
      end
      OPC_JALR, OPC_OPI: begin
        d_imm = {{20{hd[31]}}, hd[31:20]};
        d_rs  = 1'b1;
      end
      OPC_LD: begin
        d_imm = {{20{hd[31]}}, hd[31:20]};
        d_lsb = 1'b1;
      end
      OPC_ST: begin
        d_imm   = {{20{hd[31]}}, hd[31:25], hd[11:7]};
        d_lsb   = 1'b1;
        d_store = 1'b1;
        use2    = 1'b1;
        d_rd    = 5'd0;
      end
      OPC_BR: begin
        d_imm = {{19{hd[31]}}, hd[31], hd[7], hd[30:25], hd[11:8], 1'b0};
        d_rs  = 1'b1;
        use2  = 1'b1;
        d_rd  = 5'd0;
      end
      OPC_OP: begin
        d_rs = 1'b1;
        use2 = 1'b1;
      end
      default: ;
    endcase
  end

  // The register file only learns of a dispatch on the next edge, so forward it here.
  assign fwd1 = fire & (out_rd != 5'd0) & (out_rd == rs1_index);
  assign fwd2 = fire & (out_rd != 5'd0) & (out_rd == rs2_index);
  assign op1  = resolve(use1, fwd1, out_rob_id, rs1_dirty, rs1_value, rs1_rob_entry, rs1_rob_rdy,
                        rs1_rob_value, cdb_valid & (cdb_rob_id == rs1_rob_entry), cdb_value);
  assign op2  = resolve(use2, fwd2, out_rob_id, rs2_dirty, rs2_value, rs2_rob_entry, rs2_rob_rdy,
                        rs2_rob_value, cdb_valid & (cdb_rob_id == rs2_rob_entry), cdb_value);
  assign snp1 = out_rs1_need_rob & cdb_valid & (cdb_rob_id == out_rs1_rob_id);
  assign snp2 = out_rs2_need_rob & cdb_valid & (cdb_rob_id == out_rs2_rob_id);

  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[tail] <= if_inst;
      pc_q[tail]   <= if_pc;
      jump_q[tail] <= if_is_jump;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (rollback) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (load) head <= head + PW'(1);
        count <= count + CW'(push) - CW'(load);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid        <= 1'b0;
      out_opcode       <= '0;
      out_funct3       <= '0;
      out_funct7b5     <= 1'b0;
      out_rd           <= '0;
      out_rs1_val      <= '0;
      out_rs1_need_rob <= 1'b0;
      out_rs1_rob_id   <= '0;
      out_rs2_val      <= '0;
      out_rs2_need_rob <= 1'b0;
      out_rs2_rob_id   <= '0;
      out_imm          <= '0;
      out_lsb          <= 1'b0;
      out_store        <= 1'b0;
      out_rs           <= 1'b0;
      out_rob_id       <= '0;
      out_pc           <= '0;
      out_is_jump      <= 1'b0;
    end else if (rdy) begin
      if (rollback) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid        <= 1'b1;
        out_opcode       <= hd[6:0];
        out_funct3       <= hd[14:12];
        out_funct7b5     <= hd[30];
        out_rd           <= d_rd;
        out_rs1_val      <= op1.val;
        out_rs1_need_rob <= op1.need;
        out_rs1_rob_id   <= op1.id;
        out_rs2_val      <= op2.val;
        out_rs2_need_rob <= op2.need;
        out_rs2_rob_id   <= op2.id;
        out_imm          <= d_imm;
        out_lsb          <= d_lsb;
        out_store        <= d_store;
        out_rs           <= d_rs;
        out_rob_id       <= fire ? out_rob_id + ROB_W'(1) : next_empty_rob_entry;
        out_pc           <= pc_q[head];
        out_is_jump      <= jump_q[head];
      end else if (fire) begin
        out_valid <= 1'b0;
      end else if (out_valid) begin
        if (snp1) begin
          out_rs1_val      <= cdb_value;
          out_rs1_need_rob <= 1'b0;
        end
        if (snp2) begin
          out_rs2_val      <= cdb_value;
          out_rs2_need_rob <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - self-checking bench for decode_queue
// Directed scenarios followed by random traffic, all checked against a queue-based reference model.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int ROB_W = 4;
  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6f, OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_BR = 7'h63, OPC_LD = 7'h03, OPC_ST = 7'h23, OPC_OPI = 7'h13, OPC_OP = 7'h33;

  logic clk = 1'b0;
  logic rst, rdy, rollback, if_valid, if_ready, if_is_jump;
  logic [31:0] if_inst, if_pc;
  logic [4:0] rs1_index, rs2_index;
  logic rs1_dirty, rs2_dirty, rs1_rob_rdy, rs2_rob_rdy;
  logic [ROB_W-1:0] rs1_rob_entry, rs2_rob_entry, rs1_rob_q_entry, rs2_rob_q_entry;
  logic [31:0] rs1_value, rs2_value, rs1_rob_value, rs2_rob_value;
  logic [ROB_W-1:0] next_empty_rob_entry, cdb_rob_id;
  logic cdb_valid;
  logic [31:0] cdb_value;
  logic out_valid, out_ready, out_funct7b5, out_rs1_need_rob, out_rs2_need_rob;
  logic [6:0] out_opcode;
  logic [2:0] out_funct3;
  logic [4:0] out_rd;
  logic [31:0] out_rs1_val, out_rs2_val, out_imm, out_pc;
  logic [ROB_W-1:0] out_rs1_rob_id, out_rs2_rob_id, out_rob_id;
  logic out_lsb, out_store, out_rs, out_is_jump;
  logic [$clog2(DEPTH):0] iq_count;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc), .if_is_jump(if_is_jump),
    .rs1_index(rs1_index), .rs2_index(rs2_index),
    .rs1_dirty(rs1_dirty), .rs1_rob_entry(rs1_rob_entry), .rs1_value(rs1_value),
    .rs2_dirty(rs2_dirty), .rs2_rob_entry(rs2_rob_entry), .rs2_value(rs2_value),
    .rs1_rob_q_entry(rs1_rob_q_entry), .rs2_rob_q_entry(rs2_rob_q_entry),
    .rs1_rob_value(rs1_rob_value), .rs1_rob_rdy(rs1_rob_rdy),
    .rs2_rob_value(rs2_rob_value), .rs2_rob_rdy(rs2_rob_rdy),
    .next_empty_rob_entry(next_empty_rob_entry),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_rd(out_rd),
    .out_rs1_val(out_rs1_val), .out_rs1_need_rob(out_rs1_need_rob), .out_rs1_rob_id(out_rs1_rob_id),
    .out_rs2_val(out_rs2_val), .out_rs2_need_rob(out_rs2_need_rob), .out_rs2_rob_id(out_rs2_rob_id),
    .out_imm(out_imm), .out_lsb(out_lsb), .out_store(out_store), .out_rs(out_rs),
    .out_rob_id(out_rob_id), .out_pc(out_pc), .out_is_jump(out_is_jump), .iq_count(iq_count)
  );

  // Register file and ROB contents seen by the queue head.
  logic             rf_dirty [32];
  logic [ROB_W-1:0] rf_ent   [32];
  logic [31:0]      rf_val   [32];
  logic             rob_rdy  [16];
  logic [31:0]      rob_val  [16];

  always_comb begin
    rs1_dirty     = (rs1_index == 5'd0) ? 1'b0 : rf_dirty[rs1_index];
    rs1_rob_entry = rf_ent[rs1_index];
    rs1_value     = rf_val[rs1_index];
    rs2_dirty     = (rs2_index == 5'd0) ? 1'b0 : rf_dirty[rs2_index];
    rs2_rob_entry = rf_ent[rs2_index];
    rs2_value     = rf_val[rs2_index];
    rs1_rob_rdy   = rob_rdy[rs1_rob_q_entry];
    rs1_rob_value = rob_val[rs1_rob_q_entry];
    rs2_rob_rdy   = rob_rdy[rs2_rob_q_entry];
    rs2_rob_value = rob_val[rs2_rob_q_entry];
  end

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        jump;
  } ent_t;

  typedef struct packed {
    logic [6:0] opcode; logic [2:0] f3; logic f7; logic [4:0] rd;
    logic [31:0] v1; logic n1; logic [ROB_W-1:0] id1;
    logic [31:0] v2; logic n2; logic [ROB_W-1:0] id2;
    logic [31:0] imm; logic lsb; logic store; logic rs;
    logic [ROB_W-1:0] rob_id; logic [31:0] pc; logic jump;
  } out_t;

  ent_t mq[$];
  out_t m_out;
  logic m_ov;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] pc_ctr;

  task automatic chk(input string tag, input logic [$bits(out_t)-1:0] got, input logic [$bits(out_t)-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] imm_of(input logic [31:0] i);
    logic signed [11:0] s12;
    logic signed [12:0] s13;
    logic signed [20:0] s21;
    int v;
    v = 0;
    case (i[6:0])
      OPC_LUI, OPC_AUIPC: v = int'({i[31:12], 12'h000});
      OPC_JAL: begin s21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; v = s21; end
      OPC_JALR, OPC_LD, OPC_OPI: begin s12 = i[31:20]; v = s12; end
      OPC_ST: begin s12 = {i[31:25], i[11:7]}; v = s12; end
      OPC_BR: begin s13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; v = s13; end
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic resolve(input logic used, input logic [4:0] idx, input logic fire,
                         output logic [31:0] v, output logic need, output logic [ROB_W-1:0] id);
    logic [ROB_W-1:0] e;
    v = 0; need = 0; id = 0;
    e = rf_ent[idx];
    if (used) begin
      if (fire && m_out.rd != 0 && m_out.rd == idx) begin need = 1; id = m_out.rob_id; end
      else if (idx == 0 || !rf_dirty[idx]) v = rf_val[idx];
      else if (rob_rdy[e]) v = rob_val[e];
      else if (cdb_valid && cdb_rob_id == e) v = cdb_value;
      else begin need = 1; id = e; end
    end
  endtask

  task automatic decode(input ent_t e, input logic fire, output out_t n);
    logic [6:0] op;
    logic u1, u2;
    logic [31:0] v;
    logic nd;
    logic [ROB_W-1:0] id;
    op = e.inst[6:0];
    n = '0;
    n.opcode = op; n.f3 = e.inst[14:12]; n.f7 = e.inst[30];
    n.pc = e.pc; n.jump = e.jump;
    n.rd = (op == OPC_BR || op == OPC_ST) ? 5'd0 : e.inst[11:7];
    n.imm = imm_of(e.inst);
    n.lsb = (op == OPC_LD || op == OPC_ST);
    n.store = (op == OPC_ST);
    n.rs = (op inside {OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR, OPC_OPI, OPC_OP});
    n.rob_id = fire ? ROB_W'(m_out.rob_id + 1) : next_empty_rob_entry;
    u1 = !(op inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    u2 = (op inside {OPC_BR, OPC_ST, OPC_OP});
    resolve(u1, e.inst[19:15], fire, v, nd, id); n.v1 = v; n.n1 = nd; n.id1 = id;
    resolve(u2, e.inst[24:20], fire, v, nd, id); n.v2 = v; n.n2 = nd; n.id2 = id;
  endtask

  // Next-state of the reference, from the inputs currently presented.
  task automatic model_step();
    logic fire, dpush, load;
    ent_t e;
    out_t n;
    if (!rdy) return;
    if (rollback) begin mq.delete(); m_ov = 0; return; end
    fire  = m_ov && out_ready;
    dpush = if_valid && (mq.size() < DEPTH);
    load  = (mq.size() > 0) && (!m_ov || fire);
    if (load) begin
      e = mq.pop_front();
      decode(e, fire, n);
      m_out = n;
      m_ov = 1;
    end else if (fire) m_ov = 0;
    else if (m_ov) begin
      if (m_out.n1 && cdb_valid && cdb_rob_id == m_out.id1) begin m_out.v1 = cdb_value; m_out.n1 = 0; end
      if (m_out.n2 && cdb_valid && cdb_rob_id == m_out.id2) begin m_out.v2 = cdb_value; m_out.n2 = 0; end
    end
    if (dpush) mq.push_back('{inst: if_inst, pc: if_pc, jump: if_is_jump});
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.opcode = out_opcode; o.f3 = out_funct3; o.f7 = out_funct7b5; o.rd = out_rd;
    o.v1 = out_rs1_val; o.n1 = out_rs1_need_rob; o.id1 = out_rs1_rob_id;
    o.v2 = out_rs2_val; o.n2 = out_rs2_need_rob; o.id2 = out_rs2_rob_id;
    o.imm = out_imm; o.lsb = out_lsb; o.store = out_store; o.rs = out_rs;
    o.rob_id = out_rob_id; o.pc = out_pc; o.jump = out_is_jump;
    return o;
  endfunction

  // A waiting operand is defined by its tag, a resolved one by its value.
  function automatic out_t mask(input out_t o);
    if (o.n1) o.v1 = 0; else o.id1 = 0;
    if (o.n2) o.v2 = 0; else o.id2 = 0;
    return o;
  endfunction

  task automatic check_all();
    chk("out_valid", out_valid, m_ov);
    chk("iq_count", iq_count, mq.size());
    chk("if_ready", if_ready, mq.size() < DEPTH);
    if (m_ov) chk("out_bundle", mask(dut_out()), mask(m_out));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic present(input logic [31:0] inst);
    if_inst = inst;
    if_pc = pc_ctr;
    pc_ctr += 4;
    if_is_jump = 1'($urandom_range(0, 1));
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_bundle"}, dut_out(), '0);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_count"}, iq_count, 0);
    chk({tag, "_if_ready"}, if_ready, 1'b1);
    mq.delete();
    m_ov = 0;
    m_out = '0;
  endtask

  task automatic single(input logic [31:0] inst);
    present(inst);
    if_valid = 1;
    step();
    if_valid = 0;
    step();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 9))
      0: i[6:0] = OPC_LUI;   1: i[6:0] = OPC_AUIPC; 2: i[6:0] = OPC_JAL;
      3: i[6:0] = OPC_JALR;  4: i[6:0] = OPC_BR;    5: i[6:0] = OPC_LD;
      6: i[6:0] = OPC_ST;    7: i[6:0] = OPC_OPI;   8: i[6:0] = OPC_OP;
      default: i[6:0] = 7'($urandom);
    endcase
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  initial begin
    for (int r = 0; r < 32; r++) begin rf_dirty[r] = 0; rf_ent[r] = 0; rf_val[r] = 32'(r * 17); end
    rf_val[0] = 0;
    for (int t = 0; t < 16; t++) begin rob_rdy[t] = 0; rob_val[t] = 32'(t * 1000); end
    rst = 1; rdy = 1; rollback = 0; if_valid = 0; if_inst = 0; if_pc = 0; if_is_jump = 0;
    out_ready = 0; cdb_valid = 0; cdb_rob_id = 0; cdb_value = 0; next_empty_rob_entry = 0;
    pc_ctr = 32'h100;
    m_out = '0; m_ov = 0;
    #12;
    reset_check("reset");
    rst = 0;

    // ADDI x1,x0,5 appears one cycle after its push
    out_ready = 1; next_empty_rob_entry = 4'h7;
    single(32'h00500093);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_imm", out_imm, 32'd5);
    chk("t1_rs1_val", out_rs1_val, 32'd0);
    chk("t1_out_rs", out_rs, 1'b1);
    chk("t1_rob_id", out_rob_id, 4'h7);
    step();

    // back-pressure: fill output register plus all queue slots
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      present(32'h00000013 | (32'(k + 1) << 7));
      if_valid = 1;
      step();
    end
    chk("t2_if_ready_full", if_ready, 1'b0);
    chk("t2_count_full", iq_count, 4);
    present(32'h00000313);
    step();
    out_ready = 1;
    step();
    step();
    if_valid = 0;
    repeat (8) step();

    // ADDI x5 then ADD x6,x5,x5 forwarded from the dispatching ADDI
    next_empty_rob_entry = 4'h9;
    present(32'h00100293); if_valid = 1; step();
    present(32'h00528333); step();
    if_valid = 0; step();
    chk("t3_rs1_need", out_rs1_need_rob, 1'b1);
    chk("t3_rs1_id", out_rs1_rob_id, 4'h9);
    chk("t3_rs2_need", out_rs2_need_rob, 1'b1);
    chk("t3_rs2_id", out_rs2_rob_id, 4'h9);
    chk("t3_rob_id", out_rob_id, 4'hA);
    step();

    // stalled LW waiting on tag 3, woken by the CDB
    out_ready = 0; rf_dirty[2] = 1; rf_ent[2] = 3; cdb_valid = 0;
    single(32'h00012383);
    chk("t4_need_before", out_rs1_need_rob, 1'b1);
    chk("t4_id_before", out_rs1_rob_id, 4'h3);
    cdb_valid = 1; cdb_rob_id = 3; cdb_value = 32'h1000;
    step();
    chk("t4_val_after", out_rs1_val, 32'h1000);
    chk("t4_need_after", out_rs1_need_rob, 1'b0);
    cdb_valid = 0; rf_dirty[2] = 0; out_ready = 1;
    step();

    // rollback discards queue, output register and the concurrent push
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin present(32'h00a00113); if_valid = 1; step(); end
    chk("t5_count_pre", iq_count, 3);
    rollback = 1; present(32'h00b00113); step();
    chk("t5_count", iq_count, 0);
    chk("t5_valid", out_valid, 1'b0);
    rollback = 0; if_valid = 0; step();
    chk("t5_count_after", iq_count, 0);

    // negative immediates and routing
    out_ready = 1;
    single(32'hFE512E23);
    chk("t6_sw_imm", out_imm, 32'hFFFFFFFC);
    chk("t6_sw_rd", out_rd, 5'd0);
    chk("t6_sw_store", out_store, 1'b1);
    step();
    single(32'hFE208CE3);
    chk("t6_beq_imm", out_imm, 32'hFFFFFFF8);
    chk("t6_beq_rd", out_rd, 5'd0);
    step();
    single(32'hFF1FF0EF);
    chk("t6_jal_imm", out_imm, 32'hFFFFFFF0);
    step();
    single(32'h800001B7);
    chk("t6_lui_imm", out_imm, 32'h80000000);
    chk("t6_lui_rs", out_rs, 1'b0);
    chk("t6_lui_lsb", out_lsb, 1'b0);
    step();

    // random traffic, with one asynchronous reset in the middle
    for (int c = 0; c < 500; c++) begin
      for (int r = 1; r < 4; r++) begin
        rf_dirty[r] = 1'($urandom_range(0, 1));
        rf_ent[r] = ROB_W'($urandom_range(0, 3));
        rf_val[r] = $urandom;
      end
      for (int t = 0; t < 4; t++) begin rob_rdy[t] = 1'($urandom_range(0, 1)); rob_val[t] = $urandom; end
      rdy = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 24) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cdb_valid = 1'($urandom_range(0, 1));
      cdb_rob_id = ROB_W'($urandom_range(0, 3));
      cdb_value = $urandom;
      next_empty_rob_entry = ROB_W'($urandom);
      present(rand_inst());
      step();
      if (c == 250) begin
        rst = 1;
        #1;
        reset_check("async_rst");
        rst = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
